// File: rtl/clk_div_pkg.sv
// Shared constants, channel state encoding and period/high-time helpers for the clk_div_multi divider bank.
// Helpers work on 64-bit operands so any WIDTH up to 64 can use them.
package clk_div_pkg;

  localparam int unsigned DEFAULT_DIV  = 32'd12_000_000;
  localparam int unsigned DEFAULT_HIGH = 32'd6_000_000;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } chan_state_t;

  function automatic int unsigned calc_cw(input int unsigned channels);
    return (channels <= 2) ? 1 : $clog2(channels);
  endfunction

  // A zero divider behaves as a divide-by-one.
  function automatic logic [63:0] eff_p(input logic [63:0] div);
    return (div == 64'd0) ? 64'd1 : div;
  endfunction

  function automatic logic [63:0] eff_h(input logic [63:0] high, input logic [63:0] p);
    return (high < p) ? high : p;
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: clk_out/tick registered, one cycle from enable; shadow config applies at period wrap or while idle.
// Backpressure: holds one outstanding update; pending stays high until that update is applied.
module clk_div_channel import clk_div_pkg::*; #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned DEFAULT_DIV  = clk_div_pkg::DEFAULT_DIV,
  parameter int unsigned DEFAULT_HIGH = clk_div_pkg::DEFAULT_HIGH
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             enable,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_div,
  input  logic [WIDTH-1:0] wr_high,
  output logic             pending,
  output logic             clk_out,
  output logic             tick
);

  chan_state_t      state, state_n;
  logic [WIDTH-1:0] cnt, cnt_n, nxt;
  logic [WIDTH-1:0] act_div, act_div_n, act_high, act_high_n;
  logic [WIDTH-1:0] sh_div, sh_div_n, sh_high, sh_high_n;
  logic             pend_n, clk_n, tick_n, wrap, apply;
  logic [63:0]      new_p, new_h;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state    <= CH_IDLE;
      cnt      <= '0;
      act_div  <= WIDTH'(DEFAULT_DIV);
      act_high <= WIDTH'(DEFAULT_HIGH);
      sh_div   <= WIDTH'(DEFAULT_DIV);
      sh_high  <= WIDTH'(DEFAULT_HIGH);
      pending  <= 1'b0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      act_div  <= act_div_n;
      act_high <= act_high_n;
      sh_div   <= sh_div_n;
      sh_high  <= sh_high_n;
      pending  <= pend_n;
      clk_out  <= clk_n;
      tick     <= tick_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    act_div_n  = act_div;
    act_high_n = act_high;
    sh_div_n   = sh_div;
    sh_high_n  = sh_high;
    pend_n     = pending;
    clk_n      = 1'b0;
    tick_n     = 1'b0;
    nxt        = '0;

    wrap  = (64'(cnt) == eff_p(64'(act_div)) - 64'd1);
    apply = pending && ((state == CH_IDLE) || (enable && wrap));
    if (apply) begin
      act_div_n  = sh_div;
      act_high_n = sh_high;
      pend_n     = 1'b0;
    end
    // The wrap edge already runs with the freshly applied period/high time.
    new_p = eff_p(64'(act_div_n));
    new_h = eff_h(64'(act_high_n), new_p);

    case (state)
      CH_IDLE: begin
        cnt_n = '0;
        if (enable) begin
          state_n = CH_RUN;
          clk_n   = (new_h != 64'd0);
          tick_n  = 1'b1;
        end
      end
      CH_RUN: begin
        if (!enable) begin
          state_n = CH_IDLE;
          cnt_n   = '0;
        end else begin
          nxt    = wrap ? '0 : cnt + WIDTH'(1);
          cnt_n  = nxt;
          clk_n  = (64'(nxt) < new_h);
          tick_n = (nxt == '0);
        end
      end
      default: state_n = CH_IDLE;
    endcase

    // wr is only ever granted while pending is clear, so it never races apply.
    if (wr) begin
      sh_div_n  = wr_div;
      sh_high_n = wr_high;
      pend_n    = 1'b1;
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// Bank of CHANNELS runtime-programmable clock dividers with a shared valid/ready config port; outputs registered.
// cfg_ready drops only while the addressed channel holds an unapplied update; writes to absent channels are swallowed.
module clk_div_multi import clk_div_pkg::*; #(
  parameter int unsigned CHANNELS     = 4,
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned DEFAULT_DIV  = clk_div_pkg::DEFAULT_DIV,
  parameter int unsigned DEFAULT_HIGH = clk_div_pkg::DEFAULT_HIGH,
  localparam int unsigned CW          = calc_cw(CHANNELS)
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CW-1:0]       cfg_chan,
  input  logic [WIDTH-1:0]    cfg_div,
  input  logic [WIDTH-1:0]    cfg_high,
  input  logic [CHANNELS-1:0] enable,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] tick
);

  logic [CHANNELS-1:0]  pending;
  logic [(1<<CW)-1:0]   pend_pad;

  // Unpopulated channel slots read as never-pending, so invalid writes are always accepted.
  always_comb begin
    pend_pad                 = '0;
    pend_pad[CHANNELS-1:0]   = pending;
  end

  assign cfg_ready = !pend_pad[cfg_chan];

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic wr;
    assign wr = cfg_valid && cfg_ready && (cfg_chan == CW'(i));

    clk_div_channel #(
      .WIDTH        (WIDTH),
      .DEFAULT_DIV  (DEFAULT_DIV),
      .DEFAULT_HIGH (DEFAULT_HIGH)
    ) u_chan (
      .clk_in  (clk_in),
      .rst     (rst),
      .enable  (enable[i]),
      .wr      (wr),
      .wr_div  (cfg_div),
      .wr_high (cfg_high),
      .pending (pending[i]),
      .clk_out (clk_out[i]),
      .tick    (tick[i])
    );
  end

endmodule
